// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus, one transaction in flight at a time.
// Optional slave timeout is enabled by defining ARB_TIMEOUT_EN.
module periph_bus_arbiter #(
    parameter int              AW             = 32,
    parameter int              DW             = 32,
    parameter int              TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0]   ERR_DATA       = DW'(32'hDEAD_BEEF)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_write,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_write,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,

    output logic          s_read,
    output logic          s_write,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ack,

    output logic          grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_winner;

    // On a tie the master that did not win last time gets the bus.
    logic pick;
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req) pick = ~last_winner;
        else if (m1_req)      pick = 1'b1;
    end

    // Writes return zero data; reads return whatever the slave drove with s_ack.
    logic [DW-1:0] ack_data;
    assign ack_data = s_write ? '0 : s_rdata;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       m0_err_q;
    logic       m1_err_q;
    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{ERR_DATA, 8'(TIMEOUT_CYCLES)};
`endif

    // NOTE: all state here is sequential, so every assignment in this block is non-blocking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            grant       <= 1'b0;
            s_read      <= 1'b0;
            s_write     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state   <= BUSY;
                        grant   <= pick;
                        s_addr  <= pick ? m1_addr  : m0_addr;
                        s_wdata <= pick ? m1_wdata : m0_wdata;
                        s_write <= pick ? m1_write : m0_write;
                        s_read  <= pick ? ~m1_write : ~m0_write;
`ifdef ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end

                BUSY: begin
                    if (s_ack) begin
                        state       <= RESP;
                        s_read      <= 1'b0;
                        s_write     <= 1'b0;
                        last_winner <= grant;
                        if (grant) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= ack_data;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= ack_data;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // The final BUSY cycle without s_ack completes with an error instead.
                    else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        state       <= RESP;
                        s_read      <= 1'b0;
                        s_write     <= 1'b0;
                        last_winner <= grant;
                        if (grant) begin
                            m1_ack   <= 1'b1;
                            m1_err_q <= 1'b1;
                            m1_rdata <= ERR_DATA;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_err_q <= 1'b1;
                            m0_rdata <= ERR_DATA;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end

                RESP: begin
                    state    <= IDLE;
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
                    m0_err_q <= 1'b0;
                    m1_err_q <= 1'b0;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: single reads/writes, contention, ack filtering,
// withdrawn request, async reset mid-transaction and (with ARB_TIMEOUT_EN) timeout behaviour.
module tb_periph_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 0, m0_write = 0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack, m0_err;
    logic          m1_req = 0, m1_write = 0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack, m1_err;
    logic          s_read, s_write;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata = '0;
    logic          s_ack = 1'b0;
    logic          grant;

    periph_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_g;

        // Reset state
        #1;
        check("rst_s_read",   s_read,   0);
        check("rst_s_write",  s_write,  0);
        check("rst_grant",    grant,    0);
        check("rst_s_addr",   s_addr,   0);
        check("rst_m0_ack",   m0_ack,   0);
        check("rst_m1_ack",   m1_ack,   0);
        check("rst_m0_rdata", m0_rdata, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // CPU read of the LED register, slave acks on the first BUSY cycle
        m0_req = 1; m0_write = 0; m0_addr = 32'h8000_0000;
        tick();
        check("rd_s_read",  s_read,  1);
        check("rd_s_write", s_write, 0);
        check("rd_s_addr",  s_addr,  32'h8000_0000);
        check("rd_grant",   grant,   0);
        check("rd_m0_ack_busy", m0_ack, 0);
        s_ack = 1; s_rdata = 32'h5;
        tick();
        check("rd_m0_ack",   m0_ack,   1);
        check("rd_m0_rdata", m0_rdata, 32'h5);
        check("rd_m0_err",   m0_err,   0);
        check("rd_m1_ack",   m1_ack,   0);
        check("rd_m1_rdata", m1_rdata, 0);
        check("rd_strobe_drop", {s_read, s_write}, 2'b00);
        m0_req = 0; s_ack = 0; s_rdata = '0;
        tick();
        check("rd_m0_ack_clr",   m0_ack,   0);
        check("rd_m0_rdata_clr", m0_rdata, 0);

        // Master 1 write, slave acks on the 4th BUSY cycle
        m1_req = 1; m1_write = 1; m1_addr = 32'h8000_0000; m1_wdata = 32'h2;
        tick();
        check("wr_s_write1", s_write, 1);
        check("wr_s_read",   s_read,  0);
        check("wr_s_wdata",  s_wdata, 32'h2);
        check("wr_grant",    grant,   1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("wr_s_write%0d", i), s_write, 1);
            check($sformatf("wr_no_ack%0d", i), m1_ack, 0);
        end
        s_ack = 1; s_rdata = 32'h1234_5678;
        tick();
        check("wr_m1_ack",   m1_ack,   1);
        check("wr_m1_rdata", m1_rdata, 0);
        check("wr_m0_ack",   m0_ack,   0);
        check("wr_s_write_drop", s_write, 0);
        m1_req = 0; m1_write = 0; s_ack = 0; s_rdata = '0;
        tick();
        check("wr_m1_ack_clr", m1_ack, 0);

        // Contention: both masters requesting, grants alternate starting with master 0
        m0_addr = 32'h8000_0010; m1_addr = 32'h8000_0020;
        m0_req = 1; m1_req = 1;
        for (int t = 0; t < 4; t++) begin
            exp_g = t[0];
            tick();
            check($sformatf("ct_grant%0d", t), grant, exp_g);
            check($sformatf("ct_strobe%0d", t), {s_read, s_write}, 2'b10);
            check($sformatf("ct_addr%0d", t), s_addr, exp_g ? 32'h8000_0020 : 32'h8000_0010);
            s_ack = 1; s_rdata = 32'h100 + t;
            tick();
            check($sformatf("ct_ack%0d", t), exp_g ? m1_ack : m0_ack, 1);
            check($sformatf("ct_other_ack%0d", t), exp_g ? m0_ack : m1_ack, 0);
            check($sformatf("ct_rdata%0d", t), exp_g ? m1_rdata : m0_rdata, 32'h100 + t);
            check($sformatf("ct_other_rdata%0d", t), exp_g ? m0_rdata : m1_rdata, 0);
            check($sformatf("ct_strobe_drop%0d", t), {s_read, s_write}, 2'b00);
            if (exp_g) m1_req = 0; else m0_req = 0;
            s_ack = 0;
            tick();
            m0_req = 1; m1_req = 1;
        end
        m0_req = 0; m1_req = 0;
        tick();
        tick();

        // s_ack while idle must be ignored
        s_ack = 1; s_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        check("idle_ack_m0",    m0_ack, 0);
        check("idle_ack_m1",    m1_ack, 0);
        check("idle_ack_strobe", {s_read, s_write}, 2'b00);
        s_ack = 0; s_rdata = '0;

        // Request withdrawn after grant still completes
        m0_req = 1; m0_addr = 32'h8000_0004;
        tick();
        m0_req = 0;
        tick();
        check("wd_s_read_held", s_read, 1);
        check("wd_s_addr_held", s_addr, 32'h8000_0004);
        s_ack = 1; s_rdata = 32'h9;
        tick();
        check("wd_m0_ack",   m0_ack,   1);
        check("wd_m0_rdata", m0_rdata, 32'h9);
        s_ack = 0; s_rdata = '0;
        tick();

        // Async reset mid-BUSY; master 0 won last, so master 1 holds the bus first
        m0_req = 1; m1_req = 1; m1_write = 0;
        tick();
        check("rb_grant_pre", grant,  1);
        check("rb_s_read",    s_read, 1);
        #2 rst = 1'b0;
        #1;
        check("rb_s_read_async", s_read, 0);
        check("rb_grant_async",  grant,  0);
        #2 rst = 1'b1;
        tick();
        check("rb_grant_post", grant,  0);
        check("rb_s_read_post", s_read, 1);
        s_ack = 1; s_rdata = 32'h33;
        tick();
        check("rb_m0_ack", m0_ack, 1);
        check("rb_m1_ack", m1_ack, 0);
        m0_req = 0; m1_req = 0; s_ack = 0; s_rdata = '0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Slave never acks: error completion after 255 BUSY cycles
        m0_req = 1; m0_addr = 32'h8000_0100;
        tick();
        repeat (254) tick();
        check("to_still_busy", s_read, 1);
        check("to_no_ack_yet", m0_ack, 0);
        tick();
        check("to_m0_ack",   m0_ack,   1);
        check("to_m0_err",   m0_err,   1);
        check("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("to_m1_err",   m1_err,   0);
        check("to_strobe",   s_read,   0);
        m0_req = 0;
        tick();
        check("to_err_clr", m0_err, 0);

        // Master 1 is served normally afterwards
        m1_req = 1; m1_addr = 32'h8000_0200;
        tick();
        check("to_m1_grant", grant, 1);
        s_ack = 1; s_rdata = 32'h44;
        tick();
        check("to_m1_ack",   m1_ack,   1);
        check("to_m1_err2",  m1_err,   0);
        check("to_m1_rdata", m1_rdata, 32'h44);
        m1_req = 0; s_ack = 0; s_rdata = '0;
        tick();

        // s_ack on the 255th BUSY cycle wins over the timeout
        m0_req = 1;
        tick();
        repeat (254) tick();
        s_ack = 1; s_rdata = 32'h77;
        tick();
        check("tie_m0_ack",   m0_ack,   1);
        check("tie_m0_err",   m0_err,   0);
        check("tie_m0_rdata", m0_rdata, 32'h77);
        m0_req = 0; s_ack = 0; s_rdata = '0;
        tick();
`else
        // Without the timeout BUSY waits indefinitely
        m0_req = 1; m0_addr = 32'h8000_0100;
        tick();
        repeat (300) tick();
        check("nt_still_busy", s_read, 1);
        check("nt_no_ack",     m0_ack, 0);
        check("nt_no_err",     m0_err, 0);
        s_ack = 1; s_rdata = 32'h66;
        tick();
        check("nt_m0_ack",   m0_ack,   1);
        check("nt_m0_err",   m0_err,   0);
        check("nt_m0_rdata", m0_rdata, 32'h66);
        m0_req = 0; s_ack = 0; s_rdata = '0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
Two-master arbiter sharing the single peripheral bus, which holds the 0x8000_0000 LED register and future MMIO slaves. Master 0 is the CPU; master 1 is a secondary requester (debug/DMA). The arbiter grants round-robin, forwards one transaction at a time to the slave port, and returns a registered ack with read data to the granted master.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT_CYCLES, 255, max BUSY cycles without s_ack before error completion (8-bit counter)
ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
m0_req  in  1  master 0 (CPU) request, level
m0_write  in  1  1=write, 0=read
m0_addr  in  AW  address
m0_wdata  in  DW  write data
m0_rdata  out  DW  read data, valid while m0_ack=1
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  timeout flag, qualified by m0_ack
m1_req, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err  as m0_*, for master 1
s_read  out  1  slave read strobe, held through BUSY
s_write  out  1  slave write strobe, held through BUSY
s_addr  out  AW  slave address
s_wdata  out  DW  slave write data
s_rdata  in  DW  slave read data, valid with s_ack
s_ack  in  1  slave completion
grant  out  1  current owner (0/1), valid in BUSY/RESP

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; last_winner=1, so master 0 wins the first tie; timeout counter 0.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE: sample requests. One request: grant it. Both: grant !last_winner. None: stay.
- Grant edge: register grant, addr, wdata and write into the slave-side registers. Next cycle: state BUSY; s_read or s_write=1; exactly one is ever high.
- BUSY: strobes and s_addr/s_wdata held stable. s_ack=1 at an edge -> RESP, latch s_rdata into granted mN_rdata (writes latch 0), mN_ack=1, strobes drop to 0, last_winner=grant.
- RESP: exactly one cycle. Requests are not sampled. Then IDLE with all ack/err and strobes 0.
- Master rule: req, write, addr and wdata are held stable from req high until ack. Master drops req at the edge ending its ack cycle. The arbiter never reissues a completed transaction.
- Minimum transaction: 3 cycles (req cycle, BUSY with s_ack, RESP). Back-to-back transactions from one master cost 1 idle cycle.
- Non-granted mN_ack, mN_err and mN_rdata remain 0.
- s_ack outside BUSY is ignored.
- Request withdrawn after grant: the transaction still completes. Ack is issued and ignored by the master.
- Reset mid-transaction: strobes drop immediately (async). The slave tolerates an aborted access. After reset, arbitration restarts with master 0 priority.

Optional Feature:
ARB_TIMEOUT_EN defined:
- An 8-bit counter clears on BUSY entry and increments each BUSY cycle without s_ack.
- When the count reaches TIMEOUT_CYCLES: go to RESP with mN_err=1, mN_rdata=ERR_DATA, strobes dropped, last_winner updated.
- s_ack in the same cycle as the count reaching TIMEOUT_CYCLES wins: normal completion, err=0.

ARB_TIMEOUT_EN undefined:
- No counter; BUSY waits indefinitely.
- m0_err and m1_err tied 0.

Test Plan:
- CPU read only: m0_req, addr 0x8000_0000, write=0; slave acks with s_rdata=0x5 on the first BUSY cycle -> s_read high 1 cycle; m0_ack pulse on the 3rd cycle; m0_rdata=0x5; m1 outputs stay 0.
- Write pass-through: m1 writes 0x8000_0000 / 0x2; slave acks after 4 cycles -> s_write high 4 cycles; s_wdata=0x2; grant=1; m1_ack for 1 cycle; m1_rdata=0.
- Contention: both req continuously from reset; 4 transactions -> grants 0,1,0,1; never two strobes high at once.
- Timeout (ARB_TIMEOUT_EN): m0 read, s_ack never asserted -> m0_ack and m0_err after 255 BUSY cycles; m0_rdata=0xDEAD_BEEF. Next m1 request is served normally.
- Ack/timeout tie (ARB_TIMEOUT_EN): s_ack on the 255th BUSY cycle -> err=0; rdata=s_rdata.
- Reset mid-BUSY: rst low during s_read -> s_read=0 without waiting for a clock edge. After release with both requesting, master 0 is granted first.
